// File: rtl/shift_pkg.sv
// Shared constants for the shift/rotate execution unit: mode codes and FSM state encoding.
package shift_pkg;

    // Operation modes carried on in_mode
    localparam logic [1:0] SHM_SLL = 2'b00;
    localparam logic [1:0] SHM_SRA = 2'b01;
    localparam logic [1:0] SHM_ROR = 2'b10;
    localparam logic [1:0] SHM_ROL = 2'b11;

    // Control FSM states
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// One stage of a log shifter: moves data by 2^idx positions according to mode.
module shift_step
    import shift_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] idx,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result_c
);

    localparam int unsigned SH_W = AMT_W + 1;

    logic [SH_W-1:0]         sh;
    logic [2*WIDTH-1:0]      ror_w;
    logic [2*WIDTH-1:0]      rol_w;
    logic signed [WIDTH-1:0] sdata;

    // Rotates use a doubled word so the wrapped bits fall out of a plain shift
    always_comb begin
        sh       = SH_W'(1) << idx;
        sdata    = data;
        ror_w    = {data, data} >> sh;
        rol_w    = {data, data} << sh;
        result_c = data;
        case (mode)
            SHM_SLL: result_c = data << sh;
            SHM_SRA: result_c = sdata >>> sh;
            SHM_ROR: result_c = ror_w[WIDTH-1:0];
            SHM_ROL: result_c = rol_w[2*WIDTH-1:WIDTH];
            default: result_c = data;
        endcase
    end

endmodule : shift_step

// File: rtl/shift_rot_unit.sv
// Multi-cycle shift/rotate unit: applies one amount bit per cycle through a single
// log-shifter stage, stopping as soon as no higher amount bits remain.
module shift_rot_unit
    import shift_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             busy
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [AMT_W-1:0] idx;
    logic [AMT_W-1:0] idx_nxt;
    logic [AMT_W-1:0] amt_reg;
    logic [AMT_W-1:0] amt_nxt;
    logic [1:0]       mode_reg;
    logic [1:0]       mode_nxt;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic             valid_nxt;
    logic             zero_nxt;
    logic             busy_nxt;

    logic [WIDTH-1:0] step_c;
    logic [AMT_W-1:0] rest_c;
    logic             apply_c;
    logic             last_c;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data     (work),
        .idx      (idx),
        .mode     (mode_reg),
        .result_c (step_c)
    );

    // Accept only when idle; a flush in the same cycle blocks the handshake
    assign in_ready = (state == ST_IDLE) && !flush;
    assign out_data = work;

    // Current amount bit and whether any higher bits are still pending
    always_comb begin
        rest_c  = amt_reg >> idx;
        apply_c = rest_c[0];
        last_c  = ((rest_c >> 1) == '0) || (idx == AMT_W'(AMT_W - 1));
    end

    // Next-state and datapath decode; flush overrides everything
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        amt_nxt   = amt_reg;
        mode_nxt  = mode_reg;
        work_nxt  = work;

        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    work_nxt  = in_data;
                    amt_nxt   = in_amt;
                    mode_nxt  = in_mode;
                    idx_nxt   = '0;
                    state_nxt = (in_amt == '0) ? ST_HOLD : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (apply_c) begin
                    work_nxt = step_c;
                end
                idx_nxt = idx + AMT_W'(1);
                if (last_c) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (flush) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
        end

        valid_nxt = (state_nxt == ST_HOLD);
        zero_nxt  = valid_nxt && (work_nxt == '0);
        busy_nxt  = (state_nxt != ST_IDLE);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Working register, latched operands and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            amt_reg   <= '0;
            mode_reg  <= SHM_SLL;
            work      <= '0;
            out_valid <= 1'b0;
            out_zero  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            idx       <= idx_nxt;
            amt_reg   <= amt_nxt;
            mode_reg  <= mode_nxt;
            work      <= work_nxt;
            out_valid <= valid_nxt;
            out_zero  <= zero_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule : shift_rot_unit

// File: tb/tb_shift_rot_unit.sv
// Self-checking bench for shift_rot_unit (WIDTH=16): directed cases plus random ops
// compared against a bit-by-bit behavioural model.
module tb_shift_rot_unit;

    localparam int unsigned W = 16;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [3:0]    in_amt;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;
    logic          busy;

    int checks = 0;
    int errors = 0;

    shift_rot_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference result: shifts via operators, rotates one bit position at a time
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] d, input int a, input logic [1:0] m);
        logic [W-1:0] r;
        r = d;
        case (m)
            2'b00: r = d << a;
            2'b01: r = W'($signed(d) >>> a);
            2'b10: for (int k = 0; k < a; k++) r = {r[0], r[W-1:1]};
            default: for (int k = 0; k < a; k++) r = {r[W-2:0], r[W-1]};
        endcase
        return r;
    endfunction

    // Cycles from accept edge to out_valid: 1 for zero, else highest set bit + 2
    function automatic int ref_lat(input int a);
        int hb;
        if (a == 0) return 1;
        hb = 0;
        for (int b = 0; b < 4; b++) if (((a >> b) & 1) == 1) hb = b;
        return hb + 2;
    endfunction

    task automatic start_op(input logic [W-1:0] d, input logic [3:0] a, input logic [1:0] m);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [W-1:0] exp, input int lat);
        int n;
        n = 1;
        while (!out_valid && n < 20) begin
            chk("zero_when_invalid", 32'(out_zero), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("latency", 32'(n), 32'(lat));
        chk("out_data", 32'(out_data), 32'(exp));
        chk("out_zero", 32'(out_zero), 32'(exp == '0));
    endtask

    task automatic hold_and_release(input logic [W-1:0] exp, input int delay);
        for (int k = 0; k < delay; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(exp));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drop_valid", 32'(out_valid), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] d, input logic [3:0] a, input logic [1:0] m,
                          input logic [W-1:0] exp, input int delay);
        start_op(d, a, m);
        wait_result(exp, ref_lat(int'(a)));
        hold_and_release(exp, delay);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [3:0]   a;
        logic [1:0]   m;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors
        run_op(16'h9F0A, 4'd4,  2'b10, 16'hA9F0, 0);
        run_op(16'hEC21, 4'd0,  2'b10, 16'hEC21, 1);
        run_op(16'hC2E5, 4'd7,  2'b10, 16'hCB85, 0);
        run_op(16'hC2E5, 4'd7,  2'b00, 16'h7280, 0);
        run_op(16'h8000, 4'd7,  2'b01, 16'hFF00, 0);
        run_op(16'h7000, 4'd3,  2'b01, 16'h0E00, 0);
        run_op(16'hF0F0, 4'd15, 2'b10, 16'hE1E1, 0);
        run_op(16'hF0F0, 4'd1,  2'b11, 16'hE1E1, 2);
        run_op(16'h8000, 4'd1,  2'b00, 16'h0000, 0);
        run_op(16'h8001, 4'd1,  2'b00, 16'h0002, 0);

        // Backpressure with a competing request that must be ignored
        start_op(16'h0001, 4'd15, 2'b00);
        wait_result(16'h8000, 5);
        in_data  = 16'h1234;
        in_amt   = 4'd2;
        in_mode  = 2'b11;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h8000);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_drop", 32'(out_valid), 32'd0);
        chk("bp_ready_again", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(ref_result(16'h1234, 2, 2'b11), 3);
        hold_and_release(ref_result(16'h1234, 2, 2'b11), 0);

        // Flush in the second SHIFT cycle
        start_op(16'hABCD, 4'd8, 2'b10);
        @(posedge clk); #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk("flush_no_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("flush_idle_busy", 32'(busy), 32'd0);
        run_op(16'h00F0, 4'd4, 2'b00, 16'h0F00, 0);

        // Asynchronous reset in the middle of SHIFT
        start_op(16'h5A5A, 4'd15, 2'b11);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk("arst_no_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        run_op(16'h0F0F, 4'd4, 2'b10, 16'hF0F0, 0);

        // Random operations against the model
        for (int t = 0; t < 200; t++) begin
            d = W'($urandom);
            a = 4'($urandom_range(0, 15));
            m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) d = '0;
            run_op(d, a, m, ref_result(d, int'(a), m), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_rot_unit
